// File: rtl/idft_if.sv
// Stream bundle between a frequency-bin source and the inverse DFT engine.
// The master drives bins in and accepts samples out; the slave is the engine.
interface idft_if #(
    parameter int W_IN  = 17,
    parameter int W_OUT = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W_IN-1:0]  in_re;
    logic signed [W_IN-1:0]  in_im;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W_OUT-1:0] out_re;
    logic signed [W_OUT-1:0] out_im;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, busy
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, busy
    );
endinterface

// File: rtl/idft_engine.sv
// Sequential inverse DFT: loads N bins, then for each output sample n runs N
// complex MACs against an internal twiddle table, scales by 1/N and saturates.
// Optional build macro IDFT_ROUND_EN: round-half-up before the final shift
// instead of truncating toward -infinity.
module idft_engine #(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int W_IN  = 17,
    parameter int W_OUT = 16
) (
    input logic   clk,
    input logic   rst,
    idft_if.slave bus
);
    localparam int LOGN  = $clog2(N);
    localparam int ACC_W = W_IN + W + 2 + LOGN;
    localparam int SHIFT = (W - 1) + LOGN;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
    localparam logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};
`ifdef IDFT_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) <<< (SHIFT - 1);
`endif

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_FINAL, S_OUTPUT} state_t;

    // Twiddle entry round(trig(2*pi*idx/N) * (2^(W-1)-1)); evaluated at elaboration only.
    function automatic logic signed [W-1:0] tw_entry(input int idx, input bit is_sin);
        real ang;
        real val;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
        val = (is_sin ? $sin(ang) : $cos(ang)) * real'((1 << (W - 1)) - 1);
        if (val >= 0.0) return W'($rtoi(val + 0.5));
        else            return W'(-$rtoi(-val + 0.5));
    endfunction

    function automatic logic signed [W_OUT-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(OUT_MAX))      return OUT_MAX;
        else if (v < ACC_W'(OUT_MIN)) return OUT_MIN;
        else                          return v[W_OUT-1:0];
    endfunction

    logic signed [W-1:0] cos_tab [N];
    logic signed [W-1:0] sin_tab [N];

    for (genvar g = 0; g < N; g++) begin : g_twiddle
        localparam logic signed [W-1:0] COS_V = tw_entry(g, 1'b0);
        localparam logic signed [W-1:0] SIN_V = tw_entry(g, 1'b1);
        assign cos_tab[g] = COS_V;
        assign sin_tab[g] = SIN_V;
    end

    state_t                  state_q;
    logic [LOGN-1:0]         kcnt_q, k_q, n_q, m_q;
    logic signed [W_IN-1:0]  buf_re_q [N];
    logic signed [W_IN-1:0]  buf_im_q [N];
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q;
    logic                    in_ready_q, out_valid_q, out_last_q, busy_q;
    logic signed [W_OUT-1:0] out_re_q, out_im_q;

    logic signed [W_IN-1:0]   x_re, x_im;
    logic signed [W-1:0]      c_tw, s_tw;
    logic signed [W_IN+W-1:0] p_rc, p_is, p_rs, p_ic;
    logic signed [ACC_W-1:0]  acc_re_d, acc_im_d, rnd_re, rnd_im;
    logic signed [W_OUT-1:0]  fin_re_d, fin_im_d;
    logic                     load_hs;

    assign load_hs = (state_q == S_LOAD) && bus.in_valid;

    assign x_re = buf_re_q[k_q];
    assign x_im = buf_im_q[k_q];
    assign c_tw = cos_tab[m_q];
    assign s_tw = sin_tab[m_q];
    assign p_rc = x_re * c_tw;
    assign p_is = x_im * s_tw;
    assign p_rs = x_re * s_tw;
    assign p_ic = x_im * c_tw;

    // Next accumulator value for the current MAC and the scaled, saturated result.
    always_comb begin
        // NOTE: blocking '=' in combinational logic, and every output gets a value before any branch so no latch is inferred.
        acc_re_d = acc_re_q + ACC_W'(p_rc) - ACC_W'(p_is);
        acc_im_d = acc_im_q + ACC_W'(p_rs) + ACC_W'(p_ic);
        rnd_re   = acc_re_q;
        rnd_im   = acc_im_q;
`ifdef IDFT_ROUND_EN
        rnd_re   = acc_re_q + RND_BIAS;
        rnd_im   = acc_im_q + RND_BIAS;
`endif
        fin_re_d = saturate(rnd_re >>> SHIFT);
        fin_im_d = saturate(rnd_im >>> SHIFT);
    end

    // Bin buffer write port, addressed by arrival order.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are don't-care until a full frame is loaded.
        if (load_hs) begin
            buf_re_q[kcnt_q] <= bus.in_re;
            buf_im_q[kcnt_q] <= bus.in_im;
        end
    end

    // Control FSM with MAC datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            kcnt_q      <= '0;
            k_q         <= '0;
            n_q         <= '0;
            m_q         <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_hs) begin
                        kcnt_q <= kcnt_q + 1'b1;
                        if (kcnt_q == LAST_IDX) begin
                            state_q    <= S_COMPUTE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            n_q        <= '0;
                            k_q        <= '0;
                            m_q        <= '0;
                            acc_re_q   <= '0;
                            acc_im_q   <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                    k_q      <= k_q + 1'b1;
                    m_q      <= m_q + n_q;
                    if (k_q == LAST_IDX) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    out_re_q    <= fin_re_d;
                    out_im_q    <= fin_im_d;
                    out_last_q  <= (n_q == LAST_IDX);
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (n_q != LAST_IDX) begin
                            n_q      <= n_q + 1'b1;
                            k_q      <= '0;
                            m_q      <= '0;
                            acc_re_q <= '0;
                            acc_im_q <= '0;
                            state_q  <= S_COMPUTE;
                        end else begin
                            kcnt_q     <= '0;
                            n_q        <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_idft_engine.sv
// Scoreboard bench for idft_engine: a direct-summation IDFT model fills an
// expectation queue per frame; a monitor pops and compares on every output
// handshake and also watches latency, backpressure hold and in_ready behaviour.
module tb_idft_engine;
    localparam int  N     = 16;
    localparam int  W     = 16;
    localparam int  W_IN  = 17;
    localparam int  W_OUT = 16;
    localparam int  SHIFT = (W - 1) + 4;
    localparam real PI    = 3.14159265358979323846;
`ifdef IDFT_ROUND_EN
    localparam int  DC_EXP  = 1000;
    localparam int  ONE_EXP = 1000;
`else
    localparam int  DC_EXP  = 999;
    localparam int  ONE_EXP = 999;
`endif

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    idft_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus_if ();

    idft_engine #(.N(N), .W(W), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   fr_re [N];
    int   fr_im [N];
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: stall sample 3
    bit   bp_done  = 1'b0;
    int   out_idx  = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Spec twiddle value: round(trig * (2^(W-1)-1)).
    function automatic longint tw(input int m, input bit is_sin);
        real a;
        real v;
        a = 2.0 * PI * real'(m) / real'(N);
        v = (is_sin ? $sin(a) : $cos(a)) * 32767.0;
        return longint'($rtoi($floor(v + 0.5)));
    endfunction

    // x[n] = floor(sum_k X[k]*tw / 2^SHIFT), optionally rounded, then clamped.
    function automatic int scale_sat(input longint s);
        int q;
`ifdef IDFT_ROUND_EN
        s = s + (longint'(1) << (SHIFT - 1));
`endif
        q = $rtoi($floor(real'(s) / real'(longint'(1) << SHIFT)));
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic push_model();
        for (int n = 0; n < N; n++) begin
            longint sr;
            longint si;
            exp_t   e;
            sr = 0;
            si = 0;
            for (int k = 0; k < N; k++) begin
                int m;
                m  = (k * n) % N;
                sr += longint'(fr_re[k]) * tw(m, 1'b0) - longint'(fr_im[k]) * tw(m, 1'b1);
                si += longint'(fr_re[k]) * tw(m, 1'b1) + longint'(fr_im[k]) * tw(m, 1'b0);
            end
            e.re   = scale_sat(sr);
            e.im   = scale_sat(si);
            e.last = (n == N - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_frame();
        int guard;
        push_model();
        for (int k = 0; k < N; k++) begin
            if (rdy_mode == 1) begin
                bus_if.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            bus_if.in_valid = 1'b1;
            bus_if.in_re    = W_IN'(fr_re[k]);
            bus_if.in_im    = W_IN'(fr_im[k]);
            guard = 0;
            @(negedge clk);
            while (!bus_if.in_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) check("in_ready_timeout", bus_if.in_ready, 1);
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) check("drain_timeout", sb_q.size(), 0);
        #1;
    endtask

    task automatic random_frame();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = int'($urandom_range(0, 131071)) - 65536;
            fr_im[k] = int'($urandom_range(0, 131071)) - 65536;
        end
    endtask

    // Monitor: scoreboard pops, hold-stability, latency and in_ready rules.
    initial begin
        exp_t e;
        bit   prev_valid = 1'b0;
        bit   hold_pend  = 1'b0;
        bit   last_done  = 1'b0;
        bit   ref_ok     = 1'b0;
        int   ref_cyc    = 0;
        int   bins_in    = 0;
        logic signed [W_OUT-1:0] held_re, held_im;
        logic held_last;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                hold_pend  = 1'b0;
                last_done  = 1'b0;
                ref_ok     = 1'b0;
                bins_in    = 0;
                out_idx    = 0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", bus_if.out_valid, 1);
                    check("hold_re", bus_if.out_re, held_re);
                    check("hold_im", bus_if.out_im, held_im);
                    check("hold_last", bus_if.out_last, held_last);
                end
                if (last_done) begin
                    check("in_ready_after_last", bus_if.in_ready, 1);
                    check("busy_after_last", bus_if.busy, 0);
                    last_done = 1'b0;
                end
                if (bus_if.busy) check("in_ready_while_busy", bus_if.in_ready, 0);
                if (bus_if.out_valid && !prev_valid && ref_ok) begin
                    check("out_valid_latency", cyc - ref_cyc, N + 1);
                    ref_ok = 1'b0;
                end
                if (bus_if.in_valid && bus_if.in_ready) begin
                    bins_in++;
                    if (bins_in == N) begin
                        bins_in = 0;
                        ref_cyc = cyc + 1;
                        ref_ok  = 1'b1;
                    end
                end
                if (bus_if.out_valid && bus_if.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", bus_if.out_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("out_re[%0d]", out_idx), bus_if.out_re, e.re);
                        check($sformatf("out_im[%0d]", out_idx), bus_if.out_im, e.im);
                        check($sformatf("out_last[%0d]", out_idx), bus_if.out_last, e.last);
                    end
                    ref_cyc = cyc + 1;
                    ref_ok  = 1'b1;
                    if (bus_if.out_last) begin
                        last_done = 1'b1;
                        ref_ok    = 1'b0;
                        out_idx   = 0;
                    end else begin
                        out_idx++;
                    end
                end
                hold_pend  = bus_if.out_valid && !bus_if.out_ready;
                held_re    = bus_if.out_re;
                held_im    = bus_if.out_im;
                held_last  = bus_if.out_last;
                prev_valid = bus_if.out_valid;
            end
        end
    end

    // Downstream ready generator.
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 2 && !bp_done && bus_if.out_valid && out_idx == 3) begin
                bus_if.out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                bp_done          = 1'b1;
                bus_if.out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                bus_if.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus_if.out_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst             = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_re    = '0;
        bus_if.in_im    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus_if.in_ready, 1);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_out_re", bus_if.out_re, 0);
        check("rst_out_im", bus_if.out_im, 0);
        check("rst_out_last", bus_if.out_last, 0);
        check("rst_busy", bus_if.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DC bin, ready tied high
        rdy_mode = 0;
        foreach (fr_re[k]) begin fr_re[k] = 0; fr_im[k] = 0; end
        fr_re[0] = 16000;
        send_frame();
        for (int n = 0; n < N; n++) begin sb_q[n].re = DC_EXP; sb_q[n].im = 0; end
        wait_drain();

        // Single bin X[1], random ready
        rdy_mode = 1;
        foreach (fr_re[k]) begin fr_re[k] = 0; fr_im[k] = 0; end
        fr_re[1] = 16000;
        send_frame();
        sb_q[0].re  = ONE_EXP; sb_q[0].im  = 0;
        sb_q[4].re  = 0;       sb_q[4].im  = ONE_EXP;
        sb_q[8].re  = -1000;   sb_q[8].im  = 0;
        sb_q[12].re = 0;       sb_q[12].im = -1000;
        wait_drain();

        // Saturation
        rdy_mode = 0;
        foreach (fr_re[k]) begin fr_re[k] = 65535; fr_im[k] = 0; end
        send_frame();
        sb_q[0].re = 32767;
        wait_drain();

        // Backpressure on sample 3, plus ignored in_valid pulses while busy
        rdy_mode = 2;
        bp_done  = 1'b0;
        random_frame();
        send_frame();
        for (int i = 0; i < 40; i++) begin
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.in_re    = W_IN'($urandom);
            bus_if.in_im    = W_IN'($urandom);
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        wait_drain();

        // Random frames with random ready
        rdy_mode = 1;
        repeat (4) begin
            random_frame();
            send_frame();
            wait_drain();
        end

        // Reset during COMPUTE of n=5
        rdy_mode = 0;
        random_frame();
        send_frame();
        guard = 0;
        while (out_idx != 5 && guard < 2000) begin @(posedge clk); guard++; end
        if (guard >= 2000) check("reach_n5_timeout", out_idx, 5);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", bus_if.in_ready, 1);
        check("midrst_out_valid", bus_if.out_valid, 0);
        check("midrst_busy", bus_if.busy, 0);
        check("midrst_out_re", bus_if.out_re, 0);
        repeat (30) @(posedge clk);
        #1;

        // DC frame after the abort
        foreach (fr_re[k]) begin fr_re[k] = 0; fr_im[k] = 0; end
        fr_re[0] = 16000;
        send_frame();
        for (int n = 0; n < N; n++) begin sb_q[n].re = DC_EXP; sb_q[n].im = 0; end
        wait_drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
